// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple dual-port synchronous RAM with byte enables and clear engine
//
// Optional feature macro: RAM_SDP_PARITY_EN (per-byte even parity storage and read check).
//
// Ports:
//   clk      - clock, all logic on rising edge
//   rst_n    - asynchronous active-low reset
//   clr      - single-cycle pulse, starts a zero-fill sweep when idle
//   busy     - high while reset is asserted or a clear sweep runs
//   we       - write enable
//   wr_addr  - write address
//   wr_be    - byte enables, bit i covers wr_data[8i+7:8i]
//   wr_data  - write data
//   re       - read enable
//   rd_addr  - read address
//   rd_data  - read data, holds its value when rd_valid is low
//   rd_valid - one-cycle strobe marking a read result
//   rd_perr  - parity error on the current read, qualified by rd_valid
module ram_sdp_be #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_perr
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    // Clear engine: one zero word per cycle while sweeping, DEPTH cycles total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (&cnt_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;

    logic idle;
    assign idle = (state_q == ST_IDLE);

    // Single physical write port shared by the sweep and the user.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_be;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_be    = wr_be;
        mem_wdata = wr_data;
        if (!idle) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_be    = '1;
            mem_wdata = '0;
        end else begin
            mem_we    = we;
        end
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef RAM_SDP_PARITY_EN
    logic [NB-1:0]     par_q [DEPTH];
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
`ifdef RAM_SDP_PARITY_EN
                    par_q[mem_addr][i]        <= ^mem_wdata[8*i +: 8];
`endif
                end
            end
        end
    end

    // Read side. Array reads see the pre-edge contents, so RDW_MODE=0 needs
    // nothing extra; RDW_MODE=1 overlays the bytes being written this edge.
    logic              rd_fire;
    logic              fwd;
    logic [DATA_W-1:0] rd_word;
    logic              rd_err;

    assign rd_fire = re && idle;
    assign fwd     = (RDW_MODE != 0) && we && idle && (wr_addr == rd_addr);

    always_comb begin
        rd_word = mem_q[rd_addr];
        rd_err  = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (fwd && wr_be[i]) begin
                // Forwarded bytes carry freshly computed parity, so they never flag.
                rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
`ifdef RAM_SDP_PARITY_EN
            else begin
                rd_err = rd_err | ((^mem_q[rd_addr][8*i +: 8]) ^ par_q[rd_addr][i]);
            end
`endif
        end
    end

    // First output stage: strobe every cycle, data/error only on a read.
    logic              v1_q;
    logic [DATA_W-1:0] d1_q;
    logic              e1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            e1_q <= 1'b0;
        end else begin
            v1_q <= rd_fire;
            if (rd_fire) begin
                d1_q <= rd_word;
                e1_q <= rd_err;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              v2_q;
            logic [DATA_W-1:0] d2_q;
            logic              e2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                    e2_q <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        d2_q <= d1_q;
                        e2_q <= e1_q;
                    end
                end
            end

            assign rd_valid = v2_q;
            assign rd_data  = d2_q;
`ifdef RAM_SDP_PARITY_EN
            assign rd_perr  = e2_q;
`else
            assign rd_perr  = 1'b0;
`endif
        end else begin : g_no_out_reg
            assign rd_valid = v1_q;
            assign rd_data  = d1_q;
`ifdef RAM_SDP_PARITY_EN
            assign rd_perr  = e1_q;
`else
            assign rd_perr  = 1'b0;
`endif
        end
    endgenerate

endmodule
